// File: rtl/agen_seq_pkg.sv
// ---------------------------------------------------------------------------
// agen_seq_pkg
// Shared types and constants for the address-generator sequencer.
//   state_t : sequencer FSM states (IDLE, LOAD, RUN)
//   cmd_t   : one queued pass command {mode, len}
//   SIZE    : lane count of the address generator
//   DEPTH   : bank depth, the generator's modulus
//   SHIFT   : lane rotation applied by a shift pass
//   LEN_W   : width of the command length field
// ---------------------------------------------------------------------------
package agen_seq_pkg;

    localparam int SIZE  = 257;
    localparam int DEPTH = 85;
    localparam int SHIFT = 85;
    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    typedef struct packed {
        logic             mode;
        logic [LEN_W-1:0] len;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Small synchronous FIFO holding pass commands waiting for the sequencer.
//   clk     : clock, rising edge
//   reset   : synchronous, active-low
//   i_flush : empties the FIFO on the next edge (abort)
//   i_push  : write i_data (ignored when full unless a pop frees the slot)
//   i_data  : command to store
//   i_pop   : drop the head entry (ignored when empty)
//   o_data  : head entry, valid while o_empty is low
//   o_full  : all CMD_DEPTH entries occupied
//   o_empty : no entries stored
// ---------------------------------------------------------------------------
module cmd_fifo
    import agen_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_flush,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cmd_t             r_mem [CMD_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(CMD_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (reset && !i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because CMD_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/agen_sequencer.sv
// ---------------------------------------------------------------------------
// agen_sequencer
// Queues pass commands and sequences the 257-lane address generator through
// init (agen_reset), mode select and per-beat advance, presenting each beat
// to the bank-access stage with a valid/ready/last handshake.
//   clk, reset          : clock; synchronous active-low reset
//   cmd_valid/cmd_ready : command port; cmd_ready = FIFO not full
//   cmd_mode, cmd_len   : 0 = increment / 1 = shift pass; beats (0 = empty)
//   abort               : flush queued commands and stop the current pass
//   addr_valid/ready    : beat handshake to the consumer
//   addr_last           : final beat of the pass
//   beat_idx            : index of the current beat within the pass
//   agen_reset/mode/incr: generator controls
//   pass_done           : one-cycle pulse after a pass completes
//   busy                : not idle, or commands still queued
//   pass_count          : completed passes since reset, wraps at 255
// ---------------------------------------------------------------------------
module agen_sequencer #(
    parameter int DEPTH     = 85,
    parameter int LEN_W     = 8,
    parameter int CMD_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic             addr_last,
    output logic [LEN_W-1:0] beat_idx,
    output logic             agen_reset,
    output logic             agen_mode,
    output logic             agen_incr,
    output logic             pass_done,
    output logic             busy,
    output logic [7:0]       pass_count
);

    import agen_seq_pkg::*;

    // Reject parameter sets the generator and command format cannot support.
    generate
        if (LEN_W != agen_seq_pkg::LEN_W || DEPTH != agen_seq_pkg::DEPTH ||
            DEPTH >= SIZE || CMD_DEPTH < 2 ||
            (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_params
            $error("agen_sequencer: unsupported parameter set");
        end
    endgenerate

    state_t           r_state;
    logic             r_agen_mode;
    logic             r_agen_reset;
    logic             r_addr_valid;
    logic             r_pass_done;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat_idx;
    logic [7:0]       r_pass_count;

    cmd_t w_cmd_in;
    cmd_t w_head;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_hs;
    logic w_last;
    logic w_pass_end;
    logic w_empty_pass;

    assign w_cmd_in     = '{mode: cmd_mode, len: cmd_len};
    assign w_push       = cmd_valid && !w_full && !abort;
    assign w_hs         = r_addr_valid && addr_ready;
    assign w_last       = (r_state == RUN) && (r_beat_idx == r_len - 1'b1);
    assign w_pass_end   = w_hs && w_last;
    // The next command is taken whenever the sequencer is idle or finishing a pass.
    assign w_pop        = !abort && !w_empty && ((r_state == IDLE) || w_pass_end);
    assign w_empty_pass = w_pop && (w_head.len == '0);

    cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (abort),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sequencer FSM. The pop block after the case overrides the RUN exit so a
    // queued command goes straight to LOAD, leaving a single bubble cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_agen_mode  <= 1'b0;
            r_agen_reset <= 1'b1;
            r_addr_valid <= 1'b0;
            r_pass_done  <= 1'b0;
            r_len        <= '0;
            r_beat_idx   <= '0;
            r_pass_count <= '0;
        end else begin
            r_pass_done  <= 1'b0;
            r_agen_reset <= 1'b0;
            if (abort) begin
                r_state      <= IDLE;
                r_addr_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    LOAD: begin
                        r_beat_idx   <= '0;
                        r_addr_valid <= 1'b1;
                        r_state      <= RUN;
                    end
                    RUN: begin
                        if (w_hs) begin
                            r_beat_idx <= r_beat_idx + 1'b1;
                            if (w_last) begin
                                r_addr_valid <= 1'b0;
                                r_pass_done  <= 1'b1;
                                r_state      <= IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
                if (w_pop) begin
                    r_agen_mode <= w_head.mode;
                    r_len       <= w_head.len;
                    if (w_head.len != '0) begin
                        r_state      <= LOAD;
                        r_agen_reset <= 1'b1;
                    end else begin
                        r_pass_done <= 1'b1;
                    end
                end
                r_pass_count <= r_pass_count + 8'(w_pass_end) + 8'(w_empty_pass);
            end
        end
    end

    assign cmd_ready  = !w_full;
    assign addr_valid = r_addr_valid;
    assign addr_last  = w_last;
    assign beat_idx   = r_beat_idx;
    assign agen_reset = r_agen_reset;
    assign agen_mode  = r_agen_mode;
    // The generator holds its final addresses once the last beat is taken.
    assign agen_incr  = w_hs && !w_last;
    assign pass_done  = r_pass_done;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign pass_count = r_pass_count;

endmodule

// File: tb/tb_agen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_agen_sequencer
// Self-checking bench for agen_sequencer: a hand-derived cycle table for the
// first pass, directed multi-cycle sequences and a randomized run, all
// compared against a queue-based reference model of the command/beat rules.
// ---------------------------------------------------------------------------
module tb_agen_sequencer;

    localparam int LEN_W     = 8;
    localparam int CMD_DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmdValid;
    logic             cmdReady;
    logic             cmdMode;
    logic [LEN_W-1:0] cmdLen;
    logic             abortIn;
    logic             addrValid;
    logic             addrReady;
    logic             addrLast;
    logic [LEN_W-1:0] beatIdx;
    logic             agenReset;
    logic             agenMode;
    logic             agenIncr;
    logic             passDone;
    logic             busy;
    logic [7:0]       passCount;

    always #5 clk = ~clk;

    agen_sequencer #(
        .DEPTH     (85),
        .LEN_W     (LEN_W),
        .CMD_DEPTH (CMD_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_mode   (cmdMode),
        .cmd_len    (cmdLen),
        .abort      (abortIn),
        .addr_valid (addrValid),
        .addr_ready (addrReady),
        .addr_last  (addrLast),
        .beat_idx   (beatIdx),
        .agen_reset (agenReset),
        .agen_mode  (agenMode),
        .agen_incr  (agenIncr),
        .pass_done  (passDone),
        .busy       (busy),
        .pass_count (passCount)
    );

    typedef struct {
        bit rst;
        bit cv;
        bit cm;
        int cl;
        bit ab;
        bit ar;
    } stim_t;

    typedef struct {
        bit ready;
        bit valid;
        bit last;
        bit agenRst;
        bit mode;
        bit incr;
        bit done;
        bit busy;
        int beat;
        int count;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        bit mode;
        int len;
    } cmd_m;

    int compared   = 0;
    int mismatched = 0;

    // Observation counters, cleared per scenario
    int incrSeen, hsSeen, doneSeen, rstSeen, acceptedSeen, stallIncr, notReadySeen;

    // Reference model: queued commands plus the pass in flight
    cmd_m mQueue[$];
    bit   mLoad    = 0;
    bit   mRun     = 0;
    bit   mMode    = 0;
    bit   mAgenRst = 1;
    bit   mDone    = 0;
    int   mLen     = 0;
    int   mBeat    = 0;
    int   mCount   = 0;

    exp_t noExp;
    vec_t vecs[11];

    function automatic exp_t modelExpect(input bit ar);
        exp_t e;
        e.ready   = (mQueue.size() < CMD_DEPTH);
        e.valid   = mRun;
        e.last    = mRun && (mBeat == mLen - 1);
        e.agenRst = mAgenRst;
        e.mode    = mMode;
        e.incr    = mRun && ar && !e.last;
        e.done    = mDone;
        e.busy    = mLoad || mRun || (mQueue.size() != 0);
        e.beat    = mBeat & 255;
        e.count   = mCount;
        return e;
    endfunction

    // Advance the model across one clock edge with the inputs of this cycle
    function automatic void modelStep(input stim_t s);
        bit   push;
        bit   startNext;
        bit   nDone;
        bit   nRst;
        cmd_m c;
        push  = s.cv && (mQueue.size() < CMD_DEPTH);
        nDone = 0;
        nRst  = 0;
        if (!s.rst) begin
            mQueue.delete();
            mLoad  = 0;
            mRun   = 0;
            mMode  = 0;
            mLen   = 0;
            mBeat  = 0;
            mCount = 0;
            nRst   = 1;
        end else if (s.ab) begin
            mQueue.delete();
            mLoad = 0;
            mRun  = 0;
        end else begin
            startNext = !mLoad && !mRun;
            if (mLoad) begin
                mLoad = 0;
                mRun  = 1;
                mBeat = 0;
            end else if (mRun && s.ar) begin
                mBeat = mBeat + 1;
                if (mBeat == mLen) begin
                    mRun      = 0;
                    nDone     = 1;
                    mCount    = (mCount + 1) % 256;
                    startNext = 1;
                end
            end
            if (startNext && mQueue.size() > 0) begin
                c     = mQueue.pop_front();
                mMode = c.mode;
                mLen  = c.len;
                if (c.len == 0) begin
                    nDone  = 1;
                    mCount = (mCount + 1) % 256;
                end else begin
                    mLoad = 1;
                    nRst  = 1;
                end
            end
            if (push) begin
                mQueue.push_back('{s.cm, s.cl});
            end
        end
        mDone    = nDone;
        mAgenRst = nRst;
    endfunction

    task automatic cmp(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s/%s: got %0d, expected %0d at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        cmp(tag, "cmd_ready",  cmdReady,  e.ready);
        cmp(tag, "addr_valid", addrValid, e.valid);
        cmp(tag, "addr_last",  addrLast,  e.last);
        cmp(tag, "agen_reset", agenReset, e.agenRst);
        cmp(tag, "agen_mode",  agenMode,  e.mode);
        cmp(tag, "agen_incr",  agenIncr,  e.incr);
        cmp(tag, "pass_done",  passDone,  e.done);
        cmp(tag, "busy",       busy,      e.busy);
        cmp(tag, "beat_idx",   beatIdx,   e.beat);
        cmp(tag, "pass_count", passCount, e.count);
    endtask

    // Entered 1ns after a rising edge; drives inputs, checks at the falling
    // edge, then steps the model and returns 1ns after the next rising edge.
    // chk: 0 = check against model, 1 = check against te, 2 = no check
    task automatic applyStimulus(input stim_t s, input int chk, input exp_t te, input string tag);
        reset     = s.rst;
        cmdValid  = s.cv;
        cmdMode   = s.cm;
        cmdLen    = LEN_W'(s.cl);
        abortIn   = s.ab;
        addrReady = s.ar;
        #4;
        if (chk == 0) begin
            checkOutput(modelExpect(s.ar), tag);
        end else if (chk == 1) begin
            checkOutput(te, tag);
        end
        if (agenIncr === 1'b1) incrSeen++;
        if (agenIncr === 1'b1 && !s.ar) stallIncr++;
        if (addrValid === 1'b1 && s.ar) hsSeen++;
        if (passDone === 1'b1) doneSeen++;
        if (agenReset === 1'b1) rstSeen++;
        if (cmdReady === 1'b0) notReadySeen++;
        if (s.cv && s.rst && !s.ab && cmdReady === 1'b1) acceptedSeen++;
        modelStep(s);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit cv, input bit cm, input int cl, input bit ab, input bit ar,
                        input string tag);
        stim_t s;
        s = '{1'b1, cv, cm, cl, ab, ar};
        applyStimulus(s, 0, noExp, tag);
    endtask

    task automatic stepRst(input string tag);
        stim_t s;
        s = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        applyStimulus(s, 0, noExp, tag);
    endtask

    task automatic clearObs();
        incrSeen     = 0;
        hsSeen       = 0;
        doneSeen     = 0;
        rstSeen      = 0;
        acceptedSeen = 0;
        stallIncr    = 0;
        notReadySeen = 0;
    endtask

    initial begin
        stim_t s;
        int    firstValid;
        int    nextCmd;
        bit    acc;
        bit    found;
        int    dLens[4];
        int    baseCount;

        noExp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        dLens = '{3, 3, 4, 5};

        //            rst cv cm cl ab ar     rdy val lst ars mod inc don bsy beat cnt
        vecs[0]  = '{'{1, 0, 0, 0, 0, 1}, '{1,  0,  0,  1,  0,  0,  0,  0,  0,   0}};
        vecs[1]  = '{'{1, 1, 1, 2, 0, 1}, '{1,  0,  0,  0,  0,  0,  0,  0,  0,   0}};
        vecs[2]  = '{'{1, 0, 0, 0, 0, 1}, '{1,  0,  0,  0,  0,  0,  0,  1,  0,   0}};
        vecs[3]  = '{'{1, 0, 0, 0, 0, 0}, '{1,  0,  0,  1,  1,  0,  0,  1,  0,   0}};
        vecs[4]  = '{'{1, 0, 0, 0, 0, 0}, '{1,  1,  0,  0,  1,  0,  0,  1,  0,   0}};
        vecs[5]  = '{'{1, 0, 0, 0, 0, 1}, '{1,  1,  0,  0,  1,  1,  0,  1,  0,   0}};
        vecs[6]  = '{'{1, 0, 0, 0, 0, 1}, '{1,  1,  1,  0,  1,  0,  0,  1,  1,   0}};
        vecs[7]  = '{'{1, 1, 0, 0, 0, 1}, '{1,  0,  0,  0,  1,  0,  1,  0,  2,   1}};
        vecs[8]  = '{'{1, 0, 0, 0, 0, 1}, '{1,  0,  0,  0,  1,  0,  0,  1,  2,   1}};
        vecs[9]  = '{'{1, 0, 0, 0, 0, 1}, '{1,  0,  0,  0,  0,  0,  1,  0,  2,   2}};
        vecs[10] = '{'{1, 0, 0, 0, 0, 1}, '{1,  0,  0,  0,  0,  0,  0,  0,  2,   2}};

        reset     = 1'b0;
        cmdValid  = 1'b0;
        cmdMode   = 1'b0;
        cmdLen    = '0;
        abortIn   = 1'b0;
        addrReady = 1'b1;
        clearObs();
        @(posedge clk);
        #1;
        s = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        applyStimulus(s, 2, noExp, "init");
        applyStimulus(s, 2, noExp, "init");

        // Hand-derived first pass with a stall, then an empty pass
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].s, 1, vecs[i].e, $sformatf("vec%0d", i));
        end

        // A: mode 0, len 85, consumer always ready
        stepRst("A");
        stepRst("A");
        clearObs();
        firstValid = -1;
        step(1, 0, 85, 0, 1, "A");
        for (int k = 1; k <= 95; k++) begin
            if (firstValid < 0 && addrValid === 1'b1) firstValid = k;
            step(0, 0, 0, 0, 1, "A");
        end
        cmp("A", "first_valid_latency", firstValid, 3);
        cmp("A", "handshakes", hsSeen, 85);
        cmp("A", "incr_beats", incrSeen, 84);
        cmp("A", "pass_done_pulses", doneSeen, 1);
        cmp("A", "pass_count_end", passCount, 1);

        // B: two commands pushed back to back
        clearObs();
        step(1, 0, 4, 0, 1, "B");
        step(1, 1, 3, 0, 1, "B");
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 1, "B");
        cmp("B", "accepted", acceptedSeen, 2);
        cmp("B", "handshakes", hsSeen, 7);
        cmp("B", "pass_done_pulses", doneSeen, 2);
        cmp("B", "pass_count_end", passCount, 3);

        // C: len 10 with random consumer stalls
        clearObs();
        step(1, 0, 10, 0, 1, "C");
        for (int k = 0; k < 80; k++) step(0, 0, 0, 0, 1'($urandom_range(0, 1)), "C");
        cmp("C", "handshakes", hsSeen, 10);
        cmp("C", "incr_while_stalled", stallIncr, 0);
        cmp("C", "pass_done_pulses", doneSeen, 1);
        cmp("C", "pass_count_end", passCount, 4);

        // D: fill the FIFO while a long pass runs
        clearObs();
        step(1, 0, 20, 0, 1, "D");
        step(0, 0, 0, 0, 1, "D");
        step(0, 0, 0, 0, 1, "D");
        nextCmd = 0;
        for (int k = 0; k < 45; k++) begin
            acc = (nextCmd < 4) && (cmdReady === 1'b1);
            if (nextCmd < 4) step(1, 1'(nextCmd & 1), dLens[nextCmd], 0, 1, "D");
            else step(0, 0, 0, 0, 1, "D");
            if (acc) nextCmd++;
        end
        for (int k = 0; k < 40; k++) step(0, 0, 0, 0, 1, "D");
        cmp("D", "saw_full", notReadySeen > 0, 1);
        cmp("D", "accepted", acceptedSeen, 5);
        cmp("D", "handshakes", hsSeen, 35);
        cmp("D", "pass_done_pulses", doneSeen, 5);
        cmp("D", "pass_count_end", passCount, 9);

        // E1: empty pass
        clearObs();
        step(1, 0, 0, 0, 1, "E");
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, "E");
        cmp("E", "empty_agen_reset", rstSeen, 0);
        cmp("E", "empty_handshakes", hsSeen, 0);
        cmp("E", "empty_pass_done", doneSeen, 1);
        cmp("E", "empty_pass_count", passCount, 10);

        // E2: abort at beat 5 of 20, with a push in the abort cycle
        step(1, 1, 20, 0, 1, "E");
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (beatIdx === 8'd5 && addrValid === 1'b1) found = 1;
            else step(0, 0, 0, 0, 1, "E");
        end
        cmp("E", "reached_beat5", found, 1);
        clearObs();
        step(1, 0, 7, 1, 1, "E");
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, "E");
        cmp("E", "abort_pass_done", doneSeen, 0);
        cmp("E", "abort_agen_reset", rstSeen, 0);
        cmp("E", "abort_pass_count", passCount, 10);

        // F: reset pulse during RUN, then a clean pass
        step(1, 0, 30, 0, 1, "F");
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, "F");
        stepRst("F");
        clearObs();
        step(1, 1, 3, 0, 1, "F");
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1, "F");
        cmp("F", "handshakes", hsSeen, 3);
        cmp("F", "pass_done_pulses", doneSeen, 1);
        cmp("F", "pass_count_end", passCount, 1);

        // Random traffic: commands, stalls and occasional aborts
        baseCount = mCount;
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 6), 1'($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 3) != 0), "R");
        end
        cmp("R", "passes_progressed", mCount != baseCount, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/agen_sequencer.md
# agen_sequencer

Sequencing controller for the 257-lane address generator of the NTT memory datapath. Accepts pass commands (mode, beat count) through a valid/ready port, buffers them in a small command FIFO, and drives the generator's `reset`/`mode`/`incr` controls. Exposes each address beat to the bank-access stage with a valid/ready/last handshake. Sits between the NTT top-level scheduler and `address_generator`.

## Interface
- `DEPTH`, 85: bank depth; the generator's modulus, used only for parameter checks
- `LEN_W`, 8: width of beat count and beat index
- `CMD_DEPTH`, 2: command FIFO entries, power of two, at least 2
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO not full; does not depend on `cmd_valid`
- `cmd_mode`  in  1  0 = increment pass, 1 = shift pass
- `cmd_len`  in  LEN_W  beats in the pass; 0 = empty pass
- `abort`  in  1  flush the FIFO and stop the current pass
- `addr_valid`  out  1  generator output is a valid beat
- `addr_ready`  in  1  consumer accepts the beat
- `addr_last`  out  1  final beat of the pass, qualified by `addr_valid`
- `beat_idx`  out  LEN_W  index of the current beat within the pass
- `agen_reset`  out  1  generator init, active-high
- `agen_mode`  out  1  generator mode
- `agen_incr`  out  1  generator advance
- `pass_done`  out  1  one-cycle pulse when a pass completes
- `busy`  out  1  state is not IDLE, or the FIFO is not empty
- `pass_count`  out  8  passes completed since reset; wraps at 255 -> 0

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - FIFO empty: stay in IDLE.
  - FIFO not empty: pop the head and latch its mode into `agen_mode` and its length into `len_q`.
    - `cmd_len` != 0: go to LOAD.
    - `cmd_len` == 0: stay in IDLE, pulse `pass_done` the next cycle, increment `pass_count`. No LOAD and no beats.
- LOAD:
  - `agen_reset` = 1 for exactly one cycle, with `agen_mode` already valid, so the generator loads its mode-dependent start pattern.
  - Clear `beat_idx`, then go to RUN.
- RUN:
  - `addr_valid` = 1.
  - Handshake: `addr_valid & addr_ready`.
  - `agen_incr` = handshake & !`addr_last`. The generator holds its final addresses after the pass.
  - Each handshake increments `beat_idx`.
  - `addr_last` = (`beat_idx` == `len_q` - 1).
  - On the last handshake: pulse `pass_done` next cycle and increment `pass_count`. Then:
    - FIFO not empty: pop and go to LOAD (or handle an empty pass exactly as in IDLE).
    - FIFO empty: go to IDLE.
- `addr_ready` low in RUN: `agen_incr` = 0 and all state is held. The address must not change while stalled.
- FIFO:
  - Push on `cmd_valid & cmd_ready`; pop as described above.
  - Push and pop in the same cycle are legal when full; the count is unchanged.
- `abort`, highest priority after reset:
  - Next cycle: FIFO empty, state IDLE, `addr_valid` = 0.
  - No `pass_done` and no `pass_count` increment.
  - A push in the same cycle as `abort` is discarded.
- `agen_mode` changes only on a pop. It is held through LOAD, RUN and IDLE.

## Timing
- Reset values:
  - State IDLE, FIFO empty.
  - `agen_reset` = 1 (the generator is initialised while the controller is held in reset).
  - `agen_mode` = 0, `agen_incr` = 0, `addr_valid` = 0, `addr_last` = 0.
  - `beat_idx` = 0, `pass_done` = 0, `pass_count` = 0, `busy` = 0.
  - `cmd_ready` = 1 in the first cycle after reset is released.
- First beat latency, for a command accepted at the edge ending cycle T with the controller idle:
  - T+1: IDLE, pop.
  - T+2: LOAD.
  - T+3: RUN, `addr_valid` = 1.
- Back-to-back passes: last handshake at cycle L, LOAD at L+1, first beat of the next pass at L+2. This is exactly one bubble cycle.
- `pass_done` is registered: it is high in the cycle after the last handshake.
- `agen_incr` and `addr_last` are combinational from state, `beat_idx` and `addr_ready`. All other outputs are registered.
- Reset asserted mid-pass: the next cycle shows the reset values above. No partial `pass_done`.

## Structure
- Package `agen_seq_pkg`:
  - state enum `{IDLE, LOAD, RUN}`
  - command struct `{mode, len[LEN_W-1:0]}`
  - constants `SIZE` = 257, `DEPTH` = 85, `SHIFT` = 85
- Sub-module `cmd_fifo`: synchronous FIFO of command structs, `CMD_DEPTH` entries, with full/empty flags and a flush input driven by `abort`.

## Test plan
- Mode 0, len 85, `addr_ready` held at 1 -> `addr_valid` first high 3 cycles after acceptance. 85 beats, `beat_idx` 0..84, `agen_incr` high on 84 beats, `addr_last` on beat 84, then `pass_done` and `pass_count` = 1.
- Two commands (mode 0 len 4, mode 1 len 3) pushed on consecutive cycles -> `cmd_ready` stays 1. Beats 4 + bubble + 3, with `agen_mode` switching to 1 in the LOAD cycle. `pass_count` = 2.
- Random `addr_ready` stalls on a len-10 pass -> `agen_incr` never high while `addr_ready` = 0, `beat_idx` held during stalls, exactly 10 handshakes, one `pass_done`.
- Fill the FIFO (CMD_DEPTH = 2) while a pass is running -> `cmd_ready` = 0 after 2 pushes. A push coinciding with a pop is accepted, and no command is lost or duplicated.
- `cmd_len` = 0 -> no `agen_reset`, no beats, `pass_done` one cycle after the pop. `abort` mid-pass at beat 5 of 20 -> IDLE next cycle, FIFO empty, no `pass_done`, `pass_count` unchanged.
- `reset` low for 1 cycle during RUN -> all outputs at their reset values, `agen_reset` = 1. The next command starts cleanly at `beat_idx` 0.
